// File: rtl/usb_pkg.sv
// Shared types and constants for the full-speed USB receive path.
package usb_pkg;

  typedef enum logic [1:0] {
    J   = 2'd0,
    K   = 2'd1,
    SE0 = 2'd2
  } line_sym_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ERROR = 3'd4
  } rx_state_e;

  localparam int STUFF_LIMIT_DEFAULT    = 6;
  localparam int SYNC_MIN_ZEROS_DEFAULT = 5;

  // Phase count at which a bit cell is sampled (centre of a 4-clock cell).
  localparam logic [1:0] SAMPLE_PHASE = 2'd2;

  // SE0 overrides the D+ level; otherwise D+ high is J, low is K.
  function automatic line_sym_e decode_symbol(input logic j, input logic se0);
    if (se0) begin
      return SE0;
    end else if (j) begin
      return J;
    end else begin
      return K;
    end
  endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Bit-timing recovery: synchronizes the raw pad levels, decodes the line
// symbol and emits one sample strobe per bit cell, realigned on every edge.
module usb_rx_dpll
  import usb_pkg::*;
(
  input  logic      clk_48,
  input  logic      rst_n,
  input  logic      rx_j,
  input  logic      rx_se0,
  output logic      sample_stb,
  output line_sym_e symbol
);

  logic      jMeta_q;
  logic      jSync_q;
  logic      se0Meta_q;
  logic      se0Sync_q;
  line_sym_e symNow;
  line_sym_e sym_q;
  logic [1:0] phase_q;
  logic [1:0] phase_d;

  // Two-flop synchronizer; the line idles in J so reset to J levels.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      jMeta_q   <= 1'b1;
      jSync_q   <= 1'b1;
      se0Meta_q <= 1'b0;
      se0Sync_q <= 1'b0;
    end else begin
      jMeta_q   <= rx_j;
      jSync_q   <= jMeta_q;
      se0Meta_q <= rx_se0;
      se0Sync_q <= se0Meta_q;
    end
  end

  assign symNow = decode_symbol(jSync_q, se0Sync_q);

  // Any symbol change restarts the cell; otherwise the phase free-runs mod 4.
  always_comb begin
    phase_d = phase_q + 2'd1;
    if (symNow != sym_q) begin
      phase_d = 2'd0;
    end
  end

  // Phase counter and the symbol it is timing.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      sym_q   <= J;
    end else begin
      phase_q <= phase_d;
      sym_q   <= symNow;
    end
  end

  assign sample_stb = (phase_q == SAMPLE_PHASE);
  assign symbol     = sym_q;

endmodule

// File: rtl/usb_fs_rx.sv
// Full-speed USB receiver: NRZI decode, bit unstuffing, SYNC/EOP detection
// and LSB-first byte assembly on top of the recovered bit strobe.
module usb_fs_rx
  import usb_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEFAULT,
  parameter int STUFF_LIMIT    = STUFF_LIMIT_DEFAULT
) (
  input  logic       clk_48,
  input  logic       rst_n,
  input  logic       rx_j,
  input  logic       rx_se0,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_err
);

  localparam logic [3:0] StuffLim = 4'(STUFF_LIMIT);
  localparam logic [3:0] SyncMin  = 4'(SYNC_MIN_ZEROS);

  logic      sampleStb;
  line_sym_e sym;

  usb_rx_dpll u_dpll (
    .clk_48     (clk_48),
    .rst_n      (rst_n),
    .rx_j       (rx_j),
    .rx_se0     (rx_se0),
    .sample_stb (sampleStb),
    .symbol     (sym)
  );

  rx_state_e  state_q,    state_d;
  line_sym_e  lastSym_q,  lastSym_d;
  logic [3:0] zeroCnt_q,  zeroCnt_d;
  logic [3:0] onesCnt_q,  onesCnt_d;
  logic [2:0] bitCnt_q,   bitCnt_d;
  logic [7:0] shift_q,    shift_d;
  logic [7:0] rxData_q,   rxData_d;
  logic       rxValid_q,  rxValid_d;
  logic       rxActive_q, rxActive_d;
  logic       rxEop_q,    rxEop_d;
  logic       rxErr_q,    rxErr_d;
  logic       eopErr_q,   eopErr_d;
  logic [2:0] jRun_q,     jRun_d;
  logic       errSe0_q,   errSe0_d;
  logic       nrziBit;
  logic [7:0] shifted;

  // Receive FSM: acts only on sample strobes; strobes are pulsed for one cycle.
  always_comb begin
    state_d    = state_q;
    lastSym_d  = lastSym_q;
    zeroCnt_d  = zeroCnt_q;
    onesCnt_d  = onesCnt_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    rxActive_d = rxActive_q;
    rxEop_d    = 1'b0;
    rxErr_d    = 1'b0;
    eopErr_d   = eopErr_q;
    jRun_d     = jRun_q;
    errSe0_d   = errSe0_q;
    nrziBit    = (sym == lastSym_q);
    shifted    = {nrziBit, shift_q[7:1]};

    if (sampleStb) begin
      if (sym != SE0) begin
        lastSym_d = sym;
      end
      case (state_q)
        IDLE: begin
          if (sym == K) begin
            state_d   = SYNC;
            zeroCnt_d = 4'd1;
            onesCnt_d = 4'd0;
          end
        end
        SYNC: begin
          if (sym == SE0) begin
            state_d   = IDLE;
            lastSym_d = J;
          end else if (!nrziBit) begin
            zeroCnt_d = (zeroCnt_q == 4'hF) ? zeroCnt_q : zeroCnt_q + 4'd1;
            onesCnt_d = 4'd0;
          end else if (zeroCnt_q >= SyncMin) begin
            state_d    = DATA;
            rxActive_d = 1'b1;
            onesCnt_d  = 4'd1;
            bitCnt_d   = 3'd0;
            eopErr_d   = 1'b0;
          end else begin
            state_d   = IDLE;
            lastSym_d = J;
          end
        end
        DATA: begin
          if (sym == SE0) begin
            state_d  = EOP;
            eopErr_d = (bitCnt_q != 3'd0);
            rxErr_d  = (bitCnt_q != 3'd0);
          end else if (onesCnt_q >= StuffLim) begin
            if (nrziBit) begin
              state_d    = ERROR;
              rxErr_d    = 1'b1;
              rxActive_d = 1'b0;
              jRun_d     = 3'd0;
              errSe0_d   = 1'b0;
            end else begin
              onesCnt_d = 4'd0;
            end
          end else begin
            onesCnt_d = nrziBit ? onesCnt_q + 4'd1 : 4'd0;
            shift_d   = shifted;
            if (bitCnt_q == 3'd7) begin
              rxData_d  = shifted;
              rxValid_d = 1'b1;
              bitCnt_d  = 3'd0;
            end else begin
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end
        end
        EOP: begin
          if (sym != SE0) begin
            state_d    = IDLE;
            lastSym_d  = J;
            rxEop_d    = !eopErr_q;
            rxActive_d = 1'b0;
          end
        end
        ERROR: begin
          if (sym == SE0) begin
            errSe0_d = 1'b1;
            jRun_d   = 3'd0;
          end else if (sym == J) begin
            if (errSe0_q || (jRun_q == 3'd7)) begin
              state_d   = IDLE;
              lastSym_d = J;
            end else begin
              jRun_d = jRun_q + 3'd1;
            end
          end else begin
            jRun_d   = 3'd0;
            errSe0_d = 1'b0;
          end
        end
        default: begin
          state_d   = IDLE;
          lastSym_d = J;
        end
      endcase
    end
  end

  // State and output registers; reset drops any partial byte.
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lastSym_q  <= J;
      zeroCnt_q  <= 4'd0;
      onesCnt_q  <= 4'd0;
      bitCnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      rxData_q   <= 8'h00;
      rxValid_q  <= 1'b0;
      rxActive_q <= 1'b0;
      rxEop_q    <= 1'b0;
      rxErr_q    <= 1'b0;
      eopErr_q   <= 1'b0;
      jRun_q     <= 3'd0;
      errSe0_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lastSym_q  <= lastSym_d;
      zeroCnt_q  <= zeroCnt_d;
      onesCnt_q  <= onesCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      rxActive_q <= rxActive_d;
      rxEop_q    <= rxEop_d;
      rxErr_q    <= rxErr_d;
      eopErr_q   <= eopErr_d;
      jRun_q     <= jRun_d;
      errSe0_q   <= errSe0_d;
    end
  end

  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign rx_active = rxActive_q;
  assign rx_eop    = rxEop_q;
  assign rx_err    = rxErr_q;

endmodule

// File: tb/tb_usb_fs_rx.sv
// Directed bench for usb_fs_rx: a transmitter model drives NRZI/stuffed
// line symbols and a scoreboard checks delivered bytes and strobes.
`timescale 1ns/1ps
module tb_usb_fs_rx;

  logic       clk_48 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx_j   = 1'b1;
  logic       rx_se0 = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_err;

  usb_fs_rx dut (
    .clk_48    (clk_48),
    .rst_n     (rst_n),
    .rx_j      (rx_j),
    .rx_se0    (rx_se0),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_eop    (rx_eop),
    .rx_err    (rx_err)
  );

  always #10 clk_48 = ~clk_48;

  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  logic [7:0] expQ[$];
  int         validTimes[$];
  int         validCnt = 0;
  int         errCnt = 0;
  int         eopCnt = 0;
  int         activeCycles = 0;
  logic       activeAtErr = 1'b0;
  logic       prevActive = 1'b0;
  logic [7:0] expByte;
  logic       txLevel = 1'b1;
  int         txOnes = 0;
  bit         jitter = 1'b0;
  bit         longNext = 1'b0;

  // Single comparison point: counts and reports each check
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one line level for n clocks, inputs change 1ns after the edge
  task automatic applyStimulus(input logic j, input logic se0, input int n);
    rx_j   = j;
    rx_se0 = se0;
    repeat (n) @(posedge clk_48);
    #1;
  endtask

  // Nominal 4-clock bits, or alternating 5/3 when jitter is enabled
  task automatic nextPeriod(output int p);
    if (!jitter) begin
      p = 4;
    end else begin
      longNext = !longNext;
      p = longNext ? 5 : 3;
    end
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it
  task automatic sendBit(input logic b);
    int p;
    if (!b) txLevel = !txLevel;
    nextPeriod(p);
    applyStimulus(txLevel, 1'b0, p);
  endtask

  // SYNC = seven 0s then a 1 (KJKJKJKK from idle J)
  task automatic sendSync();
    txLevel = 1'b1;
    for (int i = 0; i < 7; i++) sendBit(1'b0);
    sendBit(1'b1);
    txOnes = 1;
  endtask

  // Byte LSB-first with transmitter-side stuffing after six 1s
  task automatic sendByte(input logic [7:0] b);
    expQ.push_back(b);
    for (int i = 0; i < 8; i++) begin
      sendBit(b[i]);
      txOnes = b[i] ? txOnes + 1 : 0;
      if (txOnes == 6) begin
        sendBit(1'b0);
        txOnes = 0;
      end
    end
  endtask

  // Two bit times of SE0, one J, then idle
  task automatic sendEop();
    int p;
    nextPeriod(p);
    applyStimulus(1'b1, 1'b1, p);
    nextPeriod(p);
    applyStimulus(1'b1, 1'b1, p);
    nextPeriod(p);
    applyStimulus(1'b1, 1'b0, p);
    txLevel = 1'b1;
    applyStimulus(1'b1, 1'b0, 24);
  endtask

  task automatic clearCounts();
    validCnt = 0;
    errCnt = 0;
    eopCnt = 0;
    activeCycles = 0;
    activeAtErr = 1'b0;
    validTimes.delete();
  endtask

  always @(posedge clk_48) cycle <= cycle + 1;

  // Output monitor sampling on the falling edge; pops the scoreboard on rx_valid
  always @(negedge clk_48) begin
    if (rst_n) begin
      if (rx_active) activeCycles++;
      if (rx_valid) begin
        validCnt++;
        validTimes.push_back(cycle);
        checkOutput("valid_while_active", rx_active, 1);
        checkOutput("valid_err_exclusive", rx_err, 0);
        checkOutput("scoreboard_nonempty", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          expByte = expQ.pop_front();
          checkOutput("rx_data", rx_data, expByte);
        end
      end
      if (rx_err) begin
        errCnt++;
        activeAtErr = rx_active;
      end
      if (rx_eop) begin
        eopCnt++;
        checkOutput("eop_active_fall", {prevActive, rx_active}, 2'b10);
      end
      prevActive = rx_active;
    end else begin
      prevActive = 1'b0;
    end
  end

  initial begin
    $display("[TB] reset");
    repeat (4) @(posedge clk_48);
    #1;
    checkOutput("reset_state", {rx_data, rx_valid, rx_active, rx_eop, rx_err}, 0);
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    clearCounts();
    applyStimulus(1'b1, 1'b0, 200);
    checkOutput("idle_valid", validCnt, 0);
    checkOutput("idle_err", errCnt, 0);
    checkOutput("idle_eop", eopCnt, 0);
    checkOutput("idle_active", activeCycles, 0);

    $display("[TB] clean packet A5 C3");
    clearCounts();
    sendSync();
    sendByte(8'hA5);
    sendByte(8'hC3);
    sendEop();
    checkOutput("clean_valid_count", validCnt, 2);
    if (validTimes.size() == 2)
      checkOutput("clean_byte_spacing", validTimes[1] - validTimes[0], 32);
    checkOutput("clean_eop_count", eopCnt, 1);
    checkOutput("clean_err_count", errCnt, 0);
    checkOutput("clean_data_hold", rx_data, 8'hC3);
    checkOutput("clean_active_end", rx_active, 0);
    checkOutput("clean_queue_empty", expQ.size(), 0);

    $display("[TB] stuffed FF FF");
    clearCounts();
    sendSync();
    sendByte(8'hFF);
    sendByte(8'hFF);
    sendEop();
    checkOutput("stuff_valid_count", validCnt, 2);
    if (validTimes.size() == 2)
      checkOutput("stuff_byte_spacing", validTimes[1] - validTimes[0], 36);
    checkOutput("stuff_eop_count", eopCnt, 1);
    checkOutput("stuff_err_count", errCnt, 0);
    checkOutput("stuff_queue_empty", expQ.size(), 0);

    $display("[TB] stuff violation");
    clearCounts();
    sendSync();
    for (int i = 0; i < 7; i++) sendBit(1'b1);
    sendEop();
    checkOutput("viol_err_count", errCnt, 1);
    checkOutput("viol_active_at_err", activeAtErr, 0);
    checkOutput("viol_valid_count", validCnt, 0);
    checkOutput("viol_eop_count", eopCnt, 0);
    checkOutput("viol_active_end", rx_active, 0);

    $display("[TB] misaligned EOP");
    clearCounts();
    sendSync();
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendEop();
    checkOutput("misal_err_count", errCnt, 1);
    checkOutput("misal_active_at_err", activeAtErr, 1);
    checkOutput("misal_valid_count", validCnt, 0);
    checkOutput("misal_eop_count", eopCnt, 0);
    checkOutput("misal_active_end", rx_active, 0);

    $display("[TB] jittered 3/5 bit periods carrying 3C");
    clearCounts();
    jitter = 1'b1;
    sendSync();
    sendByte(8'h3C);
    sendEop();
    jitter = 1'b0;
    checkOutput("jitter_valid_count", validCnt, 1);
    checkOutput("jitter_data", rx_data, 8'h3C);
    checkOutput("jitter_eop_count", eopCnt, 1);
    checkOutput("jitter_err_count", errCnt, 0);

    $display("[TB] reset mid-byte then recover");
    clearCounts();
    sendSync();
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    checkOutput("pre_reset_active", rx_active, 1);
    rst_n  = 1'b0;
    rx_j   = 1'b1;
    rx_se0 = 1'b0;
    @(posedge clk_48);
    #1;
    checkOutput("mid_reset_outputs", {rx_data, rx_valid, rx_active, rx_eop, rx_err}, 0);
    rst_n = 1'b1;
    txLevel = 1'b1;
    applyStimulus(1'b1, 1'b0, 20);
    clearCounts();
    sendSync();
    sendByte(8'h5A);
    sendByte(8'h81);
    sendEop();
    checkOutput("recover_valid_count", validCnt, 2);
    checkOutput("recover_eop_count", eopCnt, 1);
    checkOutput("recover_err_count", errCnt, 0);
    checkOutput("recover_queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
